// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// State and grant codes are fixed so they read the same in waveforms and in the bench.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_I_BUSY = 2'd1;
  localparam logic [1:0] ST_D_BUSY = 2'd2;

  localparam logic GNT_INSTR = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_I_BUSY = ST_I_BUSY,
    S_D_BUSY = ST_D_BUSY
  } arb_state_t;

endpackage : mem_arb_pkg

// File: rtl/arb_timeout_counter.sv
// Cycle counter for an outstanding memory access.
// expired fires during the cycle whose increment would make the count reach limit.
module arb_timeout_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Look one increment ahead so the FSM leaves BUSY exactly limit cycles after grant.
  assign expired = enable & ~clear & (r_cnt == (limit - 8'd1));

endmodule : arb_timeout_counter

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between instruction fetch and data ports.
// Holds the pipeline with stall while either port has an access outstanding.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_done,
  input  logic              data_read_en,
  input  logic              data_write_en,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  arb_state_t        r_state;
  logic              r_last_grant;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_data_rdata;
  logic              r_instr_done;
  logic              r_data_done;
  logic              r_err;

  logic w_i_elig;
  logic w_d_elig;
  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;
  logic w_expired;

  // A port in its done cycle still holds its request; masking it avoids a duplicate grant.
  assign w_i_elig  = instr_req & ~r_instr_done;
  assign w_d_elig  = (data_read_en | data_write_en) & ~r_data_done;
  assign w_idle    = (r_state == S_IDLE);
  assign w_grant_d = w_idle & w_d_elig & (~w_i_elig | (r_last_grant == GNT_INSTR));
  assign w_grant_i = w_idle & w_i_elig & ~w_grant_d;

  arb_timeout_counter u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_grant_i | w_grant_d),
    .enable  (~w_idle & ~mem_ack),
    .limit   (LIMIT),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= GNT_INSTR;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_instr      <= '0;
      r_data_rdata <= '0;
      r_instr_done <= 1'b0;
      r_data_done  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_instr_done <= 1'b0;
      r_data_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state      <= S_D_BUSY;
            r_last_grant <= GNT_DATA;
            r_mem_addr   <= data_addr;
            r_mem_we     <= data_write_en;
            r_mem_wdata  <= data_wdata;
            // Conflicting load+store is carried out as the store and flagged.
            if (data_read_en && data_write_en) begin
              r_err <= 1'b1;
            end
          end else if (w_grant_i) begin
            r_state      <= S_I_BUSY;
            r_last_grant <= GNT_INSTR;
            r_mem_addr   <= instr_addr;
            r_mem_we     <= 1'b0;
          end
        end
        S_I_BUSY: begin
          if (mem_ack) begin
            r_instr      <= mem_rdata;
            r_instr_done <= 1'b1;
            r_state      <= S_IDLE;
          end else if (w_expired) begin
            r_instr      <= '0;
            r_instr_done <= 1'b1;
            r_err        <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_D_BUSY: begin
          if (mem_ack) begin
            if (!r_mem_we) begin
              r_data_rdata <= mem_rdata;
            end
            r_data_done <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_expired) begin
            r_data_rdata <= '0;
            r_data_done  <= 1'b1;
            r_err        <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req    = ~w_idle;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign instr      = r_instr;
  assign instr_done = r_instr_done;
  assign data_rdata = r_data_rdata;
  assign data_done  = r_data_done;
  assign err        = r_err;
  assign stall      = (instr_req & ~r_instr_done) |
                      ((data_read_en | data_write_en) & ~r_data_done);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, store, timeout and reset scenarios.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        instr_done;
  logic        data_read_en;
  logic        data_write_en;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_req     (instr_req),
    .instr_addr    (instr_addr),
    .instr         (instr),
    .instr_done    (instr_done),
    .data_read_en  (data_read_en),
    .data_write_en (data_write_en),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .data_done     (data_done),
    .stall         (stall),
    .err           (err),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    instr_req = 1'b0; instr_addr = '0;
    data_read_en = 1'b0; data_write_en = 1'b0; data_addr = '0; data_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_req = 1'b0; instr_addr = '0;
    data_read_en = 1'b0; data_write_en = 1'b0; data_addr = '0; data_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, instr_done, data_done, err, stall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {mem_req, mem_we, instr_done, data_done, err, stall});
    end
    checks++;
    if ({mem_addr, mem_wdata, instr, data_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h expected 0", {mem_addr, mem_wdata, instr, data_rdata});
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: outputs cleared");
  endtask

  task automatic test_fetch();
    instr_req = 1'b1; instr_addr = 32'h10;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL fetch_stall_req: got %b expected 1", stall);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
      errors++; $display("FAIL fetch_grant: got req=%b we=%b addr=%h expected 1 0 00000010", mem_req, mem_we, mem_addr);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({mem_req, instr_done} !== 2'b10) begin
        errors++; $display("FAIL fetch_wait: got req=%b done=%b expected 1 0", mem_req, instr_done);
      end
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    checks++;
    if ({instr_done, instr, mem_req, stall} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fetch_done: got done=%b instr=%h req=%b stall=%b expected 1 deadbeef 0 0", instr_done, instr, mem_req, stall);
    end
    instr_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_done, stall, mem_req} !== 3'b000) begin
      errors++; $display("FAIL fetch_after: got done=%b stall=%b req=%b expected 0 0 0", instr_done, stall, mem_req);
    end
    $display("fetch: addr=00000010 instr=%h", instr);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    instr_req = 1'b1; instr_addr = 32'h100;
    data_read_en = 1'b1; data_addr = 32'h200;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h200}) begin
      errors++; $display("FAIL simul_data_first: got req=%b we=%b addr=%h expected 1 0 00000200", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hAAAA0001;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({data_done, data_rdata, mem_req} !== {1'b1, 32'hAAAA0001, 1'b0}) begin
      errors++; $display("FAIL simul_data_done: got done=%b rdata=%h req=%b expected 1 aaaa0001 0", data_done, data_rdata, mem_req);
    end
    @(negedge clk);
    data_read_en = 1'b0;
    checks++;
    if ({mem_req, mem_addr, data_done} !== {1'b1, 32'h100, 1'b0}) begin
      errors++; $display("FAIL simul_instr_second: got req=%b addr=%h ddone=%b expected 1 00000100 0", mem_req, mem_addr, data_done);
    end
    mem_ack = 1'b1; mem_rdata = 32'hBBBB0002;
    @(negedge clk);
    mem_ack = 1'b0;
    instr_req = 1'b0;
    checks++;
    if ({instr_done, instr, data_done} !== {1'b1, 32'hBBBB0002, 1'b0}) begin
      errors++; $display("FAIL simul_instr_done: got done=%b instr=%h ddone=%b expected 1 bbbb0002 0", instr_done, instr, data_done);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL simul_idle: got req=%b expected 0", mem_req);
    end
    $display("simultaneous: data then instr");
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr;
    apply_reset();
    instr_req = 1'b1; instr_addr = 32'h400;
    data_read_en = 1'b1; data_addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_addr = (i % 2 == 0) ? 32'h300 : 32'h400;
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, exp_addr}) begin
        errors++; $display("FAIL contention_grant%0d: got req=%b addr=%h expected 1 %h", i, mem_req, mem_addr, exp_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'h1000 + i;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (i % 2 == 0) begin
        if ({data_done, instr_done, data_rdata} !== {1'b1, 1'b0, 32'h1000 + i}) begin
          errors++; $display("FAIL contention_done%0d: got d=%b i=%b rdata=%h expected 1 0 %h", i, data_done, instr_done, data_rdata, 32'h1000 + i);
        end
      end else begin
        if ({instr_done, data_done, instr} !== {1'b1, 1'b0, 32'h1000 + i}) begin
          errors++; $display("FAIL contention_done%0d: got i=%b d=%b instr=%h expected 1 0 %h", i, instr_done, data_done, instr, 32'h1000 + i);
        end
      end
      $display("contention: txn %0d port=%s addr=%h", i, (i % 2 == 0) ? "D" : "I", exp_addr);
      if (i == 4) data_read_en = 1'b0;
      if (i == 5) instr_req = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({mem_req, err} !== 2'b00) begin
      errors++; $display("FAIL contention_end: got req=%b err=%b expected 0 0", mem_req, err);
    end
  endtask

  task automatic test_store();
    data_write_en = 1'b1; data_addr = 32'h40; data_wdata = 32'h1234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h40, 32'h1234}) begin
        errors++; $display("FAIL store_hold%0d: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000040 00001234", c, mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({data_done, data_rdata, mem_req, err} !== {1'b1, 32'h1004, 1'b0, 1'b0}) begin
      errors++; $display("FAIL store_done: got done=%b rdata=%h req=%b err=%b expected 1 00001004 0 0", data_done, data_rdata, mem_req, err);
    end
    data_write_en = 1'b0;
    @(negedge clk);
    $display("store: addr=00000040 wdata=00001234");
  endtask

  task automatic test_timeout();
    data_read_en = 1'b1; data_addr = 32'h80;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, data_done} !== 2'b10) begin
        errors++; $display("FAIL timeout_busy%0d: got req=%b done=%b expected 1 0", c, mem_req, data_done);
      end
    end
    @(negedge clk);
    checks++;
    if ({mem_req, data_done, data_rdata, err} !== {1'b0, 1'b1, 32'h0, 1'b1}) begin
      errors++; $display("FAIL timeout_abort: got req=%b done=%b rdata=%h err=%b expected 0 1 00000000 1", mem_req, data_done, data_rdata, err);
    end
    data_read_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({err, data_done, mem_req} !== 3'b100) begin
      errors++; $display("FAIL timeout_sticky: got err=%b done=%b req=%b expected 1 0 0", err, data_done, mem_req);
    end
    $display("timeout: addr=00000080 aborted err=%b", err);
  endtask

  task automatic test_ack_on_timeout_cycle();
    apply_reset();
    data_read_en = 1'b1; data_addr = 32'h90;
    repeat (4) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    @(negedge clk);
    mem_ack = 1'b0;
    data_read_en = 1'b0;
    checks++;
    if ({data_done, data_rdata, err} !== {1'b1, 32'h55, 1'b0}) begin
      errors++; $display("FAIL late_ack: got done=%b rdata=%h err=%b expected 1 00000055 0", data_done, data_rdata, err);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, err, data_done, instr_done} !== 4'b0000) begin
      errors++; $display("FAIL idle_ack: got req=%b err=%b d=%b i=%b expected 0 0 0 0", mem_req, err, data_done, instr_done);
    end
    $display("late ack: addr=00000090 rdata=%h", data_rdata);
  endtask

  task automatic test_rst_mid_access();
    apply_reset();
    instr_req = 1'b1; instr_addr = 32'h20;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: got req=%b expected 1", mem_req);
    end
    rst = 1'b1;
    instr_req = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rstmid_async_drop: got req=%b expected 0", mem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, instr_done, err, instr} !== {3'b000, 32'h0}) begin
      errors++; $display("FAIL rstmid_stray_ack: got req=%b done=%b err=%b instr=%h expected 0 0 0 00000000", mem_req, instr_done, err, instr);
    end
    $display("rst mid-access: abandoned, stray ack ignored");
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_contention();
    test_store();
    test_timeout();
    test_ack_on_timeout_cycle();
    test_rst_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
